// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: controller state encoding and load-use hazard helper
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_WAIT  = 2'd1,
    JUMP_PEND = 2'd2
  } ctrl_state_e;
  function automatic logic load_use(input logic ld, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return ld && rd != 5'd0 && (rd == rs1 || rd == rs2);
  endfunction
endpackage

// File: rtl/pipe_ctrl_stall_cnt.sv
// pipe_ctrl_stall_cnt: saturating event counter with sync clear (clear wins) and async reset
module pipe_ctrl_stall_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (en && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect sequencing for the IF-ID-EX pipeline with stall-cycle counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_load_i,
  input  logic              mdu_start_i,
  input  logic              mdu_done_i,
  input  logic              bus_hold_req_i,
  input  logic              perf_clr_i,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              id_ex_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              pc_jump_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        state_o
);
  ctrl_state_e state, state_n;
  logic [ADDR_W-1:0] pend_addr;
  logic done_pend, run, mw, jp, mdu_go, stall, jmp, bubble;
  assign run = state == RUN;
  assign mw = state == MDU_WAIT;
  assign jp = state == JUMP_PEND;
  assign mdu_go = mdu_start_i && !mdu_done_i;
  assign state_o = state;
  // a done pulse that lands under a bus wait-state is remembered until the bus frees
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      pend_addr <= '0;
      done_pend <= 1'b0;
    end else begin
      state <= state_n;
      pend_addr <= (run && bus_hold_req_i && jump_en_i) ? jump_addr_i : pend_addr;
      done_pend <= mw && bus_hold_req_i && (done_pend || mdu_done_i);
    end
  always_comb begin
    state_n = RUN;
    case (state)
      RUN:       state_n = jump_en_i ? (bus_hold_req_i ? JUMP_PEND : RUN) : (mdu_go ? MDU_WAIT : RUN);
      MDU_WAIT:  state_n = (bus_hold_req_i || !(mdu_done_i || done_pend)) ? MDU_WAIT : RUN;
      JUMP_PEND: state_n = bus_hold_req_i ? JUMP_PEND : RUN;
      default:   state_n = RUN;
    endcase
  end
  // outputs are forced quiet while reset is asserted, regardless of inputs
  always_comb begin
    stall = !rst && (bus_hold_req_i || (run && !jump_en_i && mdu_go) || (mw && !(mdu_done_i || done_pend)));
    jmp = !rst && !bus_hold_req_i && (jp || (run && jump_en_i));
    bubble = !rst && !bus_hold_req_i && run && !jump_en_i && !mdu_go
             && load_use(ex_load_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i);
    pc_hold_o = stall || bubble;
    if_id_hold_o = stall || bubble;
    id_ex_hold_o = stall;
    if_id_flush_o = jmp;
    id_ex_flush_o = jmp || bubble;
    pc_jump_o = jmp;
    pc_jump_addr_o = (jmp && jp) ? pend_addr : jump_addr_i;
  end
  pipe_ctrl_stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .clr(perf_clr_i),
    .en(pc_hold_o),
    .cnt(stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven single-cycle vectors plus directed multi-cycle sequences for pipe_ctrl
module tb_pipe_ctrl;
  logic clk, rst, j, ld, st, dn, bus, clr;
  logic [31:0] ja, addr;
  logic [4:0] rs1, rs2, rd;
  logic ph, ih, eh, iflu, eflu, pj;
  logic [3:0] cnt;
  logic [1:0] state;
  logic [5:0] o;
  logic [39:0] snap;
  int tot = 0, bad = 0;
  assign o = {ph, ih, eh, iflu, eflu, pj};
  assign snap = {o, addr, state};
  pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .jump_en_i(j), .jump_addr_i(ja),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .ex_rd_addr_i(rd), .ex_load_i(ld),
    .mdu_start_i(st), .mdu_done_i(dn), .bus_hold_req_i(bus), .perf_clr_i(clr),
    .pc_hold_o(ph), .if_id_hold_o(ih), .id_ex_hold_o(eh), .if_id_flush_o(iflu),
    .id_ex_flush_o(eflu), .pc_jump_o(pj), .pc_jump_addr_o(addr), .stall_cnt_o(cnt), .state_o(state)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic jump; logic [31:0] ja; logic [4:0] rs1, rs2, rd;
    logic ld, st, dn, bus; logic [5:0] eo; logic [31:0] ea;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got o=%b addr=%h st=%0d want o=%b addr=%h st=%0d", nm,
               act[39:34], act[33:2], act[1:0], exp[39:34], exp[33:2], exp[1:0]);
    end
  endtask
  task automatic chkc(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%0d want cnt=%0d", nm, act, exp);
    end
  endtask
  task automatic idle();
    {j, ld, st, dn, bus, clr} = '0;
    ja = 32'h0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
  endtask
  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("reset_out", snap, 40'h0);
    chkc("reset_cnt", cnt, 4'd0);
    @(negedge clk) rst = 1'b0;
    tv[0] = '{1'b0, 32'h40,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 32'h40};
    tv[1] = '{1'b0, 32'h44,  5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110010, 32'h44};
    tv[2] = '{1'b0, 32'h48,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 32'h48};
    tv[3] = '{1'b0, 32'h4c,  5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110010, 32'h4c};
    tv[4] = '{1'b0, 32'h50,  5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 32'h50};
    tv[5] = '{1'b1, 32'h100, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 32'h100};
    tv[6] = '{1'b0, 32'h54,  5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 6'b111000, 32'h54};
    tv[7] = '{1'b0, 32'h58,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 32'h58};
    tv[8] = '{1'b0, 32'h5c,  5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'b110010, 32'h5c};
    tv[9] = '{1'b0, 32'h60,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b111000, 32'h60};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      j = tv[i].jump; ja = tv[i].ja; rs1 = tv[i].rs1; rs2 = tv[i].rs2; rd = tv[i].rd;
      ld = tv[i].ld; st = tv[i].st; dn = tv[i].dn; bus = tv[i].bus;
      #1 chk($sformatf("vec%0d", i), snap, {tv[i].eo, tv[i].ea, 2'd0});
    end
    // MDU: start t0, done t4
    @(negedge clk) begin idle(); clr = 1'b1; end
    @(negedge clk) clr = 1'b0;
    #1 chkc("cnt_clr", cnt, 4'd0);
    @(negedge clk) st = 1'b1;
    #1 chk("mdu_t0", snap, {6'b111000, 32'h0, 2'd0});
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("mdu_t%0d", k), snap, {6'b111000, 32'h0, 2'd1});
    end
    @(negedge clk) dn = 1'b1;
    #1 chk("mdu_t4", snap, {6'b000000, 32'h0, 2'd1});
    @(negedge clk) begin dn = 1'b0; st = 1'b0; end
    #1 chk("mdu_t5", snap, {6'b000000, 32'h0, 2'd0});
    chkc("mdu_cnt", cnt, 4'd4);
    // bus wait-state swallows a jump, replayed once the bus frees
    @(negedge clk) bus = 1'b1;
    #1 chk("bj_t0", snap, {6'b111000, 32'h0, 2'd0});
    @(negedge clk) begin j = 1'b1; ja = 32'h200; end
    #1 chk("bj_t1", snap, {6'b111000, 32'h200, 2'd0});
    @(negedge clk) begin j = 1'b0; ja = 32'h300; end
    #1 chk("bj_t2", snap, {6'b111000, 32'h300, 2'd2});
    @(negedge clk) bus = 1'b0;
    #1 chk("bj_t3", snap, {6'b000111, 32'h200, 2'd2});
    @(negedge clk);
    #1 chk("bj_t4", snap, {6'b000000, 32'h300, 2'd0});
    // done pulse under bus hold
    @(negedge clk) begin idle(); st = 1'b1; end
    #1 chk("bm_t0", snap, {6'b111000, 32'h0, 2'd0});
    @(negedge clk) begin bus = 1'b1; dn = 1'b1; end
    #1 chk("bm_t1", snap, {6'b111000, 32'h0, 2'd1});
    @(negedge clk) dn = 1'b0;
    #1 chk("bm_t2", snap, {6'b111000, 32'h0, 2'd1});
    @(negedge clk) bus = 1'b0;
    #1 chk("bm_t3", snap, {6'b000000, 32'h0, 2'd1});
    @(negedge clk) st = 1'b0;
    #1 chk("bm_t4", snap, {6'b000000, 32'h0, 2'd0});
    // saturation and clear-while-stalling
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin clr = 1'b0; bus = 1'b1; end
    repeat (20) @(negedge clk);
    #1 chkc("cnt_sat", cnt, 4'hf);
    clr = 1'b1;
    @(negedge clk);
    #1 chkc("cnt_clr_stall", cnt, 4'd0);
    chk("clr_stall_out", snap, {6'b111000, 32'h0, 2'd0});
    // async reset in MDU_WAIT
    @(negedge clk) begin idle(); st = 1'b1; end
    @(negedge clk);
    #1 chk("pre_rst", snap, {6'b111000, 32'h0, 2'd1});
    #1 rst = 1'b1;
    #1 chk("rst_async", snap, 40'h0);
    chkc("rst_cnt", cnt, 4'd0);
    @(negedge clk) begin st = 1'b0; rst = 1'b0; end
    #1 chk("post_rst", snap, 40'h0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
